up_down_seq: RTL

UP_DOWN_SEQ -- requirements
Module: up_down_seq

---
 rtl/up_down_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/up_down_seq.sv
// -----------------------------------------------------------------------------
// up_down_seq
//
// Sweep sequencer that drives a plain 4-bit up/down counter through one of
// two waveforms between a lower and an upper bound:
//   saw      : lo -> hi, reload lo, repeated cfg_cycles times
//   triangle : lo -> hi -> lo, repeated cfg_cycles round trips
//
// The counter has no enable. Whenever the controller wants the counter to
// stand still, it asserts load with in equal to the value it is parked at.
//
// Ports
//   clk        in   1  sole clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   start      in   1  request a sweep (sampled only while idle)
//   abort      in   1  stop an active sweep; counter freezes at current value
//   cfg_lo     in   4  sweep lower bound, unsigned
//   cfg_hi     in   4  sweep upper bound, unsigned
//   cfg_mode   in   1  0 = saw, 1 = triangle
//   cfg_cycles in   4  passes (saw) or round trips (triangle), must be != 0
//   ct         in   4  current counter value
//   load       out  1  counter load strobe
//   ud         out  1  counter direction, 1 = up
//   in         out  4  counter load value
//   busy       out  1  high while a sweep is in progress
//   done       out  1  one-cycle pulse on normal completion
//   err        out  1  one-cycle pulse, the cycle after a rejected start
// -----------------------------------------------------------------------------
module up_down_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] cfg_lo,
  input  logic [3:0] cfg_hi,
  input  logic       cfg_mode,
  input  logic [3:0] cfg_cycles,
  input  logic [3:0] ct,
  output logic       load,
  output logic       ud,
  output logic [3:0] in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] park_q,  park_d;
  logic [3:0] rem_q,   rem_d;
  logic [3:0] lo_q,    lo_d;
  logic [3:0] hi_q,    hi_d;
  logic       mode_q,  mode_d;
  logic       err_q,   err_d;

  logic       load_s;
  logic       ud_s;
  logic [3:0] in_s;
  logic       busy_s;
  logic       done_s;
  logic       cfg_ok_s;
  logic       at_top_s;
  logic       at_bot_s;
  logic       last_s;

  // Configuration check applied to a start request
  always_comb begin
    cfg_ok_s = (cfg_lo <= cfg_hi) && (cfg_cycles != 4'd0);
  end

  // Window-edge detection. Using >= / <= instead of == means a counter that
  // somehow lands outside [lo, hi] is still treated as having reached the
  // edge, so the controller never commands a step past it (no 15->0 or 0->15).
  always_comb begin
    at_top_s = (ct >= hi_q);
    at_bot_s = (ct <= lo_q);
    last_s   = (rem_q == 4'd1);
  end

  // Next-state, bookkeeping and counter command decode
  always_comb begin
    state_d = state_q;
    park_d  = park_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    load_s  = 1'b1;
    ud_s    = 1'b1;
    in_s    = park_q;
    busy_s  = 1'b0;
    done_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok_s) begin
            lo_d    = cfg_lo;
            hi_d    = cfg_hi;
            mode_d  = cfg_mode;
            rem_d   = cfg_cycles;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        busy_s = 1'b1;
        if (abort) begin
          in_s    = ct;
          park_d  = ct;
          state_d = S_IDLE;
        end else begin
          in_s    = lo_q;
          state_d = S_UP;
        end
      end

      S_UP: begin
        busy_s = 1'b1;
        if (abort) begin
          in_s    = ct;
          park_d  = ct;
          state_d = S_IDLE;
        end else if (!at_top_s) begin
          load_s = 1'b0;
          ud_s   = 1'b1;
        end else if (mode_q && (lo_q != hi_q)) begin
          // Turn around; the count-down step happens on this same edge
          load_s  = 1'b0;
          ud_s    = 1'b0;
          state_d = S_DOWN;
        end else begin
          // Saw pass complete (a degenerate lo==hi triangle behaves the same)
          rem_d = rem_q - 4'd1;
          if (last_s) begin
            in_s    = hi_q;
            park_d  = hi_q;
            state_d = S_DONE;
          end else begin
            in_s    = lo_q;
            state_d = S_UP;
          end
        end
      end

      S_DOWN: begin
        busy_s = 1'b1;
        if (abort) begin
          in_s    = ct;
          park_d  = ct;
          state_d = S_IDLE;
        end else if (!at_bot_s) begin
          load_s = 1'b0;
          ud_s   = 1'b0;
        end else begin
          rem_d = rem_q - 4'd1;
          if (last_s) begin
            in_s    = lo_q;
            park_d  = lo_q;
            state_d = S_DONE;
          end else begin
            load_s  = 1'b0;
            ud_s    = 1'b1;
            state_d = S_UP;
          end
        end
      end

      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        // Unreachable encodings: hold the counter and return to idle
        state_d = S_IDLE;
      end
    endcase
  end

  // State and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      park_q  <= 4'd0;
      rem_q   <= 4'd0;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      park_q  <= park_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign load = load_s;
  assign ud   = ud_s;
  assign in   = in_s;
  assign busy = busy_s;
  assign done = done_s;
  assign err  = err_q;

endmodule
